// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over a shared memory and ALU.
// Optional feature: define MC_BNE_EN to decode bne (op 000101) through the branch-execute state.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucontrol,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_BNE_EN
    localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } aluop_t;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       fetch;
        logic       pcwrite;
        logic       branch;
        aluop_t     aluop;
    } ctrl_t;

    // State-only control word; the registered copy is loaded with the value for the state being entered.
    function automatic ctrl_t moore_ctrl(input state_t s);
        ctrl_t c;
        c       = '0;
        c.aluop = ALU_ADD;
        case (s)
            FETCH:   begin c.alusrcb = 2'b01; c.fetch = 1'b1; end
            DECODE:  c.alusrcb = 2'b11;
            MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            MEMRD:   c.iord = 1'b1;
            MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
            RTYPEEX: begin c.alusrca = 1'b1; c.aluop = ALU_FUNCT; end
            RTYPEWB: begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            BEQEX:   begin c.alusrca = 1'b1; c.aluop = ALU_SUB; c.pcsrc = 2'b01; c.branch = 1'b1; end
            ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            ADDIWB:  c.regwrite = 1'b1;
            JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t r_state;
    ctrl_t  r_ctrl;
    state_t w_next;
    logic   w_op_legal;
    ctrl_t  w_ctrl;
    logic   w_taken;

    always_comb begin
        w_op_legal = 1'b1;
        case (op)
            OP_LW, OP_SW, OP_RTYP, OP_BEQ, OP_ADDI, OP_J: w_op_legal = 1'b1;
`ifdef MC_BNE_EN
            OP_BNE:  w_op_legal = 1'b1;
`endif
            default: w_op_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:   w_next = memready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_RTYP:      w_next = RTYPEEX;
                    OP_BEQ:       w_next = BEQEX;
                    OP_ADDI:      w_next = ADDIEX;
                    OP_J:         w_next = JEX;
`ifdef MC_BNE_EN
                    OP_BNE:       w_next = BEQEX;
`endif
                    default:      w_next = FETCH;
                endcase
            end
            MEMADR:  w_next = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   w_next = memready ? MEMWB : MEMRD;
            MEMWR:   w_next = memready ? FETCH : MEMWR;
            RTYPEEX: w_next = RTYPEWB;
            ADDIEX:  w_next = ADDIWB;
            default: w_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
            r_ctrl  <= moore_ctrl(FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= moore_ctrl(w_next);
        end
    end

    // Reset overrides the registered word so the reset cycle itself never strobes.
    always_comb begin
        w_ctrl = reset ? moore_ctrl(FETCH) : r_ctrl;
`ifdef MC_BNE_EN
        w_taken = (op == OP_BNE) ? ~zero : zero;
`else
        w_taken = zero;
`endif
    end

    always_comb begin
        iord       = w_ctrl.iord;
        memwrite   = w_ctrl.memwrite;
        regdst     = w_ctrl.regdst;
        memtoreg   = w_ctrl.memtoreg;
        regwrite   = w_ctrl.regwrite;
        alusrca    = w_ctrl.alusrca;
        alusrcb    = w_ctrl.alusrcb;
        pcsrc      = w_ctrl.pcsrc;
        irwrite    = ~reset & w_ctrl.fetch & memready;
        pcen       = ~reset & ((w_ctrl.fetch & memready) | w_ctrl.pcwrite | (w_ctrl.branch & w_taken));
        illegal_op = ~reset & (r_state == DECODE) & ~w_op_legal;
        state      = reset ? 4'd0 : r_state;
        alucontrol = 3'b010;
        case (w_ctrl.aluop)
            ALU_SUB: alucontrol = 3'b110;
            ALU_FUNCT: begin
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: each instruction expands to its step sequence and every cycle is checked.
// Follows MC_BNE_EN the same way as the design.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic       illegal_op;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int zforce   = -1;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen),
        .alucontrol(alucontrol), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    typedef enum int {
        P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
        P_RTYPEEX, P_RTYPEWB, P_BEQEX, P_ADDIEX, P_ADDIWB, P_JEX
    } ph_t;

    typedef struct packed {
        logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic       pcen;
        logic [2:0] alu;
        logic       ill;
    } outs_t;

    function automatic logic op_legal(input logic [5:0] o);
        case (o)
            6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010: return 1'b1;
`ifdef MC_BNE_EN
            6'b000101: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic [3:0] ph_code(input ph_t p);
        return 4'(int'(p));
    endfunction

    function automatic outs_t model(input ph_t p, input logic mr, input logic z,
                                    input logic [5:0] o, input logic [5:0] f);
        outs_t e;
        e     = '0;
        e.alu = 3'b010;
        case (p)
            P_FETCH:   begin e.alusrcb = 2'b01; e.irwrite = mr; e.pcen = mr; end
            P_DECODE:  begin e.alusrcb = 2'b11; e.ill = ~op_legal(o); end
            P_MEMADR:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            P_MEMRD:   e.iord = 1'b1;
            P_MEMWB:   begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
            P_MEMWR:   begin e.iord = 1'b1; e.memwrite = 1'b1; end
            P_RTYPEEX: begin e.alusrca = 1'b1; e.alu = funct_alu(f); end
            P_RTYPEWB: begin e.regdst = 1'b1; e.regwrite = 1'b1; end
            P_BEQEX: begin
                e.alusrca = 1'b1; e.alu = 3'b110; e.pcsrc = 2'b01;
                e.pcen = (o == 6'b000101) ? ~z : z;
            end
            P_ADDIEX:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            P_ADDIWB:  e.regwrite = 1'b1;
            P_JEX:     begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
            default:   e = '0;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic outs_t observed();
        return {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, pcen, alucontrol, illegal_op};
    endfunction

    // Called just after a rising edge; drives one cycle and checks it on the falling edge.
    task automatic cyc(input ph_t p, input logic mr);
        memready = mr;
        zero     = (zforce < 0) ? 1'($urandom_range(0, 1)) : zforce[0];
        @(negedge clk);
        check($sformatf("%s.state", p.name()), 32'(state), 32'(ph_code(p)));
        check($sformatf("%s.outs", p.name()), 32'(observed()), 32'(model(p, mr, zero, op, funct)));
        @(posedge clk);
        #1;
    endtask

    task automatic rst_cyc();
        reset    = 1'b1;
        memready = 1'b1;
        zero     = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("RST.state", 32'(state), 32'd0);
        check("RST.outs", 32'(observed()), 32'(model(P_FETCH, 1'b0, zero, op, funct)));
        @(posedge clk);
        #1;
    endtask

    // Random don't-care memready where the FSM must ignore it.
    function automatic logic rmr();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int wf, input int wm);
        op    = o;
        funct = f;
        for (int i = 0; i < wf; i++) cyc(P_FETCH, 1'b0);
        cyc(P_FETCH, 1'b1);
        cyc(P_DECODE, rmr());
        if (op_legal(o)) begin
            case (o)
                6'b100011: begin
                    cyc(P_MEMADR, rmr());
                    for (int i = 0; i < wm; i++) cyc(P_MEMRD, 1'b0);
                    cyc(P_MEMRD, 1'b1);
                    cyc(P_MEMWB, rmr());
                end
                6'b101011: begin
                    cyc(P_MEMADR, rmr());
                    for (int i = 0; i < wm; i++) cyc(P_MEMWR, 1'b0);
                    cyc(P_MEMWR, 1'b1);
                end
                6'b000000: begin cyc(P_RTYPEEX, rmr()); cyc(P_RTYPEWB, rmr()); end
                6'b001000: begin cyc(P_ADDIEX, rmr()); cyc(P_ADDIWB, rmr()); end
                6'b000010: cyc(P_JEX, rmr());
                default:   cyc(P_BEQEX, rmr());
            endcase
        end
    endtask

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 8))
            0: return 6'b100011;
            1: return 6'b101011;
            2: return 6'b000000;
            3: return 6'b000100;
            4: return 6'b001000;
            5: return 6'b000010;
            6: return 6'b000101;
            7: return 6'b111111;
            default: return 6'b001101;
        endcase
    endfunction

    function automatic logic [5:0] pick_funct();
        case ($urandom_range(0, 5))
            0: return 6'b100000;
            1: return 6'b100010;
            2: return 6'b100100;
            3: return 6'b100101;
            4: return 6'b101010;
            default: return 6'($urandom);
        endcase
    endfunction

    function automatic int pick_wait();
        return ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    initial begin
        reset = 1'b1; op = 6'b100011; funct = '0; zero = 1'b0; memready = 1'b0;
        #1;
        rst_cyc();
        rst_cyc();
        reset = 1'b0;

        run_instr(6'b100011, 6'b000000, 0, 0);
        run_instr(6'b101011, 6'b000000, 0, 3);
        run_instr(6'b000000, 6'b101010, 0, 0);
        run_instr(6'b000000, 6'b100010, 0, 0);
        zforce = 1; run_instr(6'b000100, 6'b000000, 0, 0);
        zforce = 0; run_instr(6'b000100, 6'b000000, 0, 0);
        zforce = 0; run_instr(6'b000101, 6'b000000, 0, 0);
        zforce = 1; run_instr(6'b000101, 6'b000000, 0, 0);
        zforce = -1;
        run_instr(6'b111111, 6'b000000, 2, 0);
        run_instr(6'b000010, 6'b000000, 0, 0);
        run_instr(6'b001000, 6'b000000, 1, 0);

        // Reset while MEMRD waits on memory, then while MEMWR is strobing.
        op = 6'b100011;
        cyc(P_FETCH, 1'b1); cyc(P_DECODE, 1'b1); cyc(P_MEMADR, 1'b1);
        cyc(P_MEMRD, 1'b0); cyc(P_MEMRD, 1'b0);
        rst_cyc(); rst_cyc(); rst_cyc();
        reset = 1'b0;
        op = 6'b101011;
        cyc(P_FETCH, 1'b1); cyc(P_DECODE, 1'b0); cyc(P_MEMADR, 1'b0); cyc(P_MEMWR, 1'b0);
        rst_cyc();
        reset = 1'b0;

        for (int n = 0; n < 300; n++)
            run_instr(pick_op(), pick_funct(), pick_wait(), pick_wait());

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
